bp_queue: RTL
=============

Name: bp_queue

Overview:
- In-order FIFO of outstanding branch predictions; sits between fetch (producer of predictions) and the global-history branch predictor's update port.
- Fetch enqueues every predicted conditional branch with its PC, direction and target.
- EX resolves branches in program order. The block compares each outcome with the head entry, raises mispredict/redirect to the PC-select logic, and drives the registered predictor update (update/waddr/br_en).

Parameters:
- DEPTH, 4, number of in-flight prediction entries; must be a power of 2, at least 2.
- PTR_W, $clog2(DEPTH), pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  external pipeline flush (trap/jump redirect); discards all entries
- enq_valid  in  1  fetch presents a predicted branch
- enq_pc  in  32  branch PC
- enq_pred_take  in  1  predicted direction
- enq_pred_target  in  32  predicted target (don't-care when not taken)
- enq_ready  out  1  not full
- res_valid  in  1  EX resolves the oldest branch
- res_br_en  in  1  actual direction
- res_target  in  32  actual taken target
- mispredict  out  1  combinational; head prediction wrong
- redirect_pc  out  32  combinational; correct next PC when mispredict
- pht_update  out  1  registered update strobe to predictor
- pht_waddr  out  32  registered PC of resolved branch
- pht_br_en  out  1  registered resolved direction
- count  out  PTR_W+1  occupancy
- res_err  out  1  sticky; resolve arrived while empty

Behaviour:
- Storage: DEPTH entries {pc, pred_take, pred_target}; head/tail pointers PTR_W bits that wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
- enq_ready = (count != DEPTH). It depends only on registered state, with no combinational path from res_valid.
- Enqueue fires on enq_valid & enq_ready & ~mispredict & ~flush. The entry is written at tail and tail increments. When not fired, enq_valid is silently dropped; fetch holds it when enq_ready is low.
- Resolve fires on res_valid & (count != 0) and always pops the head.
- Resolve with count == 0 sets res_err (sticky until rst). It has no other effect: no mispredict and no update.
- mispredict = resolve-fire & ((res_br_en != head.pred_take) | (res_br_en & head.pred_take & res_target != head.pred_target)).
- redirect_pc = res_br_en ? res_target : head.pc + 4. It holds this value whenever resolve fires, and is 0 otherwise.
- On mispredict: pop the head, discard all younger entries (head = tail, count = 0), and drop any same-cycle enqueue because it is wrong-path.
- On flush: head = tail = count = 0 next cycle, and any same-cycle enqueue is dropped. A resolve that fires in the same cycle still produces its pht_* update, because the branch is architecturally resolved. mispredict is still reported combinationally and the consumer arbitrates.
- Simultaneous enqueue and resolve without mispredict: count is unchanged, both pointers advance. This is legal when full: enq_ready is already low when full, so no enqueue occurs, and one slot frees next cycle.
- Predictor update is driven one cycle after the resolve fires:
  - pht_update = 1
  - pht_waddr = head.pc
  - pht_br_en = res_br_en
  - pht_update is 0 in any cycle not following a resolve-fire.
- Reset (async, any time, including mid-burst): head = tail = 0, count = 0, enq_ready = 1, pht_update = 0, pht_waddr = 0, pht_br_en = 0, res_err = 0. mispredict = 0 and redirect_pc = 0 as a consequence. Entry payloads need no reset.
- Combinational outputs mispredict/redirect_pc depend on res_* and head registers only, never on enq_*.

Test Plan:
- Reset, then enqueue pc=0x100 (take=1, tgt=0x200); next cycle resolve br_en=1, target=0x200 -> mispredict=0, count 1->0; next cycle pht_update=1, pht_waddr=0x100, pht_br_en=1.
- Enqueue pc=0x100 (take=0), pc=0x110, pc=0x120; resolve br_en=1, target=0x400 -> mispredict=1, redirect_pc=0x400, count=0 next cycle. A same-cycle enqueue of 0x130 is dropped; pht_waddr=0x100, pht_br_en=1.
- Enqueue pc=0x200 with take=0, resolve br_en=0 -> no mispredict. Enqueue pc=0x300 with take=1, tgt=0x380, resolve br_en=1, target=0x384 -> mispredict=1, redirect_pc=0x384. Enqueue pc=0x500 with take=1, resolve br_en=0 -> redirect_pc=0x504.
- Fill 4 entries -> enq_ready=0, count=4. Resolve plus held enqueue in the same cycle -> enqueue not accepted. Next cycle count=3, enq_ready=1. Run 10 enqueue/resolve pairs so pointers wrap twice -> FIFO order preserved on pht_waddr.
- Resolve with empty queue -> res_err=1 sticky, pht_update=0, mispredict=0. Flush with 3 entries -> count=0. Flush coincident with a correct resolve -> pht_update still asserted next cycle.
- Assert rst asynchronously mid-cycle with 2 entries and a pending update -> count=0, enq_ready=1, pht_update=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/bp_queue.sv
// bp_queue: in-order FIFO of branch predictions checked against EX resolution.
// It flags mispredicts and sends registered updates to the predictor.
module bp_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  input  logic [31:0]      enq_pc,
  input  logic             enq_pred_take,
  input  logic [31:0]      enq_pred_target,
  output logic             enq_ready,
  input  logic             res_valid,
  input  logic             res_br_en,
  input  logic [31:0]      res_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             pht_update,
  output logic [31:0]      pht_waddr,
  output logic             pht_br_en,
  output logic [PTR_W:0]   count,
  output logic             res_err
);
  logic [31:0]      r_pc   [DEPTH];
  logic [31:0]      r_tgt  [DEPTH];
  logic             r_take [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;
  logic             w_res_fire, w_enq_fire, w_head_take;
  logic [31:0]      w_head_pc, w_head_tgt;

  assign w_head_pc   = r_pc[r_head];
  assign w_head_tgt  = r_tgt[r_head];
  assign w_head_take = r_take[r_head];
  assign count       = r_count;
  assign enq_ready   = r_count != (PTR_W+1)'(DEPTH);
  assign w_res_fire  = res_valid & (r_count != '0);
  assign mispredict  = w_res_fire & ((res_br_en != w_head_take) |
                       (res_br_en & w_head_take & (res_target != w_head_tgt)));
  assign redirect_pc = w_res_fire ? (res_br_en ? res_target : w_head_pc + 32'd4) : '0;
  // Enqueues in a mispredict or flush cycle are wrong-path and are discarded.
  assign w_enq_fire  = enq_valid & enq_ready & ~mispredict & ~flush;

  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_pc[r_tail]   <= enq_pc;
      r_take[r_tail] <= enq_pred_take;
      r_tgt[r_tail]  <= enq_pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      pht_update <= 1'b0;
      pht_waddr  <= '0;
      pht_br_en  <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      pht_update <= w_res_fire;
      if (w_res_fire) begin
        pht_waddr <= w_head_pc;
        pht_br_en <= res_br_en;
      end
      if (res_valid && r_count == '0) res_err <= 1'b1;
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else if (mispredict) begin
        r_head  <= r_tail;
        r_count <= '0;
      end else begin
        if (w_enq_fire) r_tail <= r_tail + 1'b1;
        if (w_res_fire) r_head <= r_head + 1'b1;
        r_count <= r_count + (PTR_W+1)'(w_enq_fire) - (PTR_W+1)'(w_res_fire);
      end
    end
  end
endmodule
